// File: rtl/pe_array_pkg.sv
// Shared dimensions, controller state encoding and PE indexing helper for the
// convolution PE array.
package pe_array_pkg;

  localparam int unsigned DEF_ARRAY_M      = 8;
  localparam int unsigned DEF_ARRAY_N      = 4;
  localparam int unsigned DEF_FILTER_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_ACCU_WIDTH   = 24;
  localparam int unsigned DEF_NUM_DATA     = 16;
  localparam int unsigned DEF_TS_WIDTH     = 8;

  // Packed vector widths; element i sits at [i*width +: width]
  localparam int unsigned DEF_IVEC_W = DEF_NUM_DATA * DEF_DATA_WIDTH;
  localparam int unsigned DEF_FVEC_W = DEF_NUM_DATA * DEF_FILTER_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } ctrl_state_e;

  function automatic int unsigned pe_index(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Single processing element: NUM_DATA-entry weight register, element select
// by the shared counter and a signed multiply-accumulate with sync clear.
module pe_mac
  import pe_array_pkg::*;
#(
  parameter int unsigned FW = DEF_FILTER_WIDTH,
  parameter int unsigned DW = DEF_DATA_WIDTH,
  parameter int unsigned AW = DEF_ACCU_WIDTH,
  parameter int unsigned ND = DEF_NUM_DATA,
  parameter int unsigned CW = $clog2(DEF_NUM_DATA)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             w_load,
  input  logic [ND*FW-1:0] w_data,
  input  logic [CW-1:0]    c_addr,
  input  logic [DW-1:0]    x_elem,
  input  logic             mac_en,
  input  logic             clr,
  output logic [AW-1:0]    accum
);

  logic [ND*FW-1:0]        w_q, w_d;
  logic [AW-1:0]           accum_q, accum_d;
  logic signed [FW-1:0]    w_elem;
  logic signed [FW+DW-1:0] prod;
  logic [AW-1:0]           prod_ext;

  always_comb begin
    w_elem   = w_q[c_addr*FW +: FW];
    prod     = w_elem * $signed(x_elem);
    prod_ext = {{(AW-FW-DW){prod[FW+DW-1]}}, prod};
    w_d      = w_load ? w_data : w_q;
    accum_d  = accum_q;
    if (clr) begin
      accum_d = '0;
    end else if (mac_en) begin
      accum_d = accum_q + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= '0;
      accum_q <= '0;
    end else if (en) begin
      w_q     <= w_d;
      accum_q <= accum_d;
    end
  end

  assign accum = accum_q;

endmodule

// File: rtl/conv_pe_array.sv
// ARRAY_M x ARRAY_N signed MAC grid with pass/timestep controller and per-row
// output register. Define PE_ARRAY_DEBUG_EN to expose the dbg_* observation ports.
module conv_pe_array
  import pe_array_pkg::*;
#(
  parameter int unsigned ARRAY_M      = DEF_ARRAY_M,
  parameter int unsigned ARRAY_N      = DEF_ARRAY_N,
  parameter int unsigned FILTER_WIDTH = DEF_FILTER_WIDTH,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ACCU_WIDTH   = DEF_ACCU_WIDTH,
  parameter int unsigned NUM_DATA     = DEF_NUM_DATA,
  parameter int unsigned TS_WIDTH     = DEF_TS_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               sys_start,
  input  logic [$clog2(ARRAY_M*ARRAY_N)-1:0] filter_addr,
  input  logic                               filter_load,
  input  logic                               input_load,
  input  logic [TS_WIDTH-1:0]                sum_timestep,
  input  logic [$clog2(ARRAY_M):0]           num_filter,
  input  logic [$clog2(ARRAY_N):0]           num_kernel,
  input  logic [NUM_DATA*DATA_WIDTH-1:0]     ibuf_read_data,
  input  logic [NUM_DATA*FILTER_WIDTH-1:0]   fbuf_read_data,
  output logic                               acc,
  output logic [ARRAY_M*ACCU_WIDTH-1:0]      obuf_write_data
`ifdef PE_ARRAY_DEBUG_EN
  ,
  output logic [$clog2(NUM_DATA)-1:0]        dbg_c_addr,
  output logic                               dbg_busy,
  output logic [ACCU_WIDTH-1:0]              dbg_pe_out_10,
  output logic [ACCU_WIDTH-1:0]              dbg_row_sum_1
`endif
);

  localparam int unsigned PE_NUM = ARRAY_M * ARRAY_N;
  localparam int unsigned FA_W   = $clog2(PE_NUM);
  localparam int unsigned CW     = $clog2(NUM_DATA);
  localparam int unsigned OB_W   = ARRAY_M * ACCU_WIDTH;

  ctrl_state_e                  state_q, state_d;
  logic                         armed_q, armed_d;
  logic [CW-1:0]                c_q, c_d;
  logic [TS_WIDTH-1:0]          ts_cnt_q, ts_cnt_d, ts_target;
  logic [NUM_DATA*DATA_WIDTH-1:0] x_q, x_d;
  logic                         acc_q, acc_d;
  logic [OB_W-1:0]              obuf_q, obuf_d;

  logic                         busy, mac_fire, out_fire, clr_all;
  logic [DATA_WIDTH-1:0]        x_elem;
  logic [PE_NUM-1:0]            w_load;
  logic [ARRAY_M-1:0]           row_act;
  logic [ARRAY_N-1:0]           col_act;
  logic [ACCU_WIDTH-1:0]        pe_acc [ARRAY_M][ARRAY_N];
  logic [ACCU_WIDTH-1:0]        row_sum [ARRAY_M];
  logic [OB_W-1:0]              row_sum_flat;

  always_comb begin
    busy   = (state_q != ST_IDLE);
    x_elem = x_q[c_q*DATA_WIDTH +: DATA_WIDTH];
    for (int unsigned m = 0; m < ARRAY_M; m++) row_act[m] = (m < 32'(num_filter));
    for (int unsigned n = 0; n < ARRAY_N; n++) col_act[n] = (n < 32'(num_kernel));
    // Out-of-range addresses match no PE, so they fall out as ignored writes
    for (int unsigned i = 0; i < PE_NUM; i++) begin
      w_load[i] = filter_load && !busy && (filter_addr == FA_W'(i));
    end
  end

  always_comb begin
    row_sum_flat = '0;
    for (int unsigned m = 0; m < ARRAY_M; m++) begin
      row_sum[m] = '0;
      for (int unsigned n = 0; n < ARRAY_N; n++) begin
        if (row_act[m] && col_act[n]) row_sum[m] = row_sum[m] + pe_acc[m][n];
      end
      row_sum_flat[m*ACCU_WIDTH +: ACCU_WIDTH] = row_sum[m];
    end
  end

  // FINISH is the edge after the last MAC: it registers the row sums and can
  // already accept the next load, giving a NUM_DATA+1 cycle pass period.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    c_d       = c_q;
    ts_cnt_d  = ts_cnt_q;
    x_d       = x_q;
    acc_d     = 1'b0;
    obuf_d    = obuf_q;
    mac_fire  = 1'b0;
    out_fire  = 1'b0;
    ts_target = (sum_timestep == '0) ? TS_WIDTH'(1) : sum_timestep;
    if (sys_start) begin
      armed_d  = 1'b1;
      ts_cnt_d = '0;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (input_load && armed_q) begin
            x_d     = ibuf_read_data;
            c_d     = '0;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          mac_fire = 1'b1;
          c_d      = c_q + 1'b1;
          if (c_q == CW'(NUM_DATA-1)) begin
            ts_cnt_d = ts_cnt_q + 1'b1;
            state_d  = ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (ts_cnt_q >= ts_target) begin
            out_fire = 1'b1;
            acc_d    = 1'b1;
            obuf_d   = row_sum_flat;
            ts_cnt_d = '0;
          end
          if (input_load && armed_q) begin
            x_d     = ibuf_read_data;
            c_d     = '0;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    clr_all = sys_start || out_fire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      armed_q  <= 1'b0;
      c_q      <= '0;
      ts_cnt_q <= '0;
      x_q      <= '0;
      acc_q    <= 1'b0;
      obuf_q   <= '0;
    end else if (enable) begin
      state_q  <= state_d;
      armed_q  <= armed_d;
      c_q      <= c_d;
      ts_cnt_q <= ts_cnt_d;
      x_q      <= x_d;
      acc_q    <= acc_d;
      obuf_q   <= obuf_d;
    end
  end

  for (genvar gm = 0; gm < ARRAY_M; gm++) begin : g_row
    for (genvar gn = 0; gn < ARRAY_N; gn++) begin : g_col
      localparam int unsigned IDX = pe_index(gm, gn, ARRAY_N);
      pe_mac #(
        .FW(FILTER_WIDTH),
        .DW(DATA_WIDTH),
        .AW(ACCU_WIDTH),
        .ND(NUM_DATA),
        .CW(CW)
      ) u_pe (
        .clk    (clk),
        .rst_n  (reset),
        .en     (enable),
        .w_load (w_load[IDX]),
        .w_data (fbuf_read_data),
        .c_addr (c_q),
        .x_elem (x_elem),
        .mac_en (mac_fire),
        .clr    (clr_all || !(row_act[gm] && col_act[gn])),
        .accum  (pe_acc[gm][gn])
      );
    end
  end

  assign acc             = acc_q & enable;
  assign obuf_write_data = obuf_q;

`ifdef PE_ARRAY_DEBUG_EN
  assign dbg_c_addr    = c_q;
  assign dbg_busy      = busy;
  assign dbg_pe_out_10 = pe_acc[1][0];
  assign dbg_row_sum_1 = row_sum[1];
`endif

endmodule

// File: tb/tb_conv_pe_array.sv
// Scoreboard bench for conv_pe_array: stimulus pushes expected row vectors and
// pulse cycles; a negedge monitor pops and compares on every acc pulse.
module tb_conv_pe_array;

  logic         clk = 1'b0;
  logic         reset, enable, sys_start, filter_load, input_load;
  logic [4:0]   filter_addr;
  logic [7:0]   sum_timestep;
  logic [3:0]   num_filter;
  logic [2:0]   num_kernel;
  logic [127:0] ibuf, fbuf;
  logic         acc;
  logic [191:0] obuf;

  typedef struct {
    logic [191:0] data;
    int unsigned  cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned pulses = 0;
  int unsigned pushes = 0;

  conv_pe_array dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sys_start       (sys_start),
    .filter_addr     (filter_addr),
    .filter_load     (filter_load),
    .input_load      (input_load),
    .sum_timestep    (sum_timestep),
    .num_filter      (num_filter),
    .num_kernel      (num_kernel),
    .ibuf_read_data  (ibuf),
    .fbuf_read_data  (fbuf),
    .acc             (acc),
    .obuf_write_data (obuf)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish before 500000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every acc pulse must match the oldest expectation, data and cycle
  initial forever begin
    @(negedge clk);
    if (acc === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_acc: got pulse at cycle %0d want none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("obuf_data", 256'(obuf), 256'(mon_e.data));
        check("acc_cycle", 256'(cyc), 256'(mon_e.cyc));
      end
    end
  end

  function automatic logic [191:0] rows_all(input logic [23:0] v);
    logic [191:0] r;
    for (int m = 0; m < 8; m++) r[m*24 +: 24] = v;
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_at(input logic [191:0] d, input int unsigned delay);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + delay;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic run_pass(input logic [127:0] x);
    ibuf = x;
    input_load = 1'b1;
    step(1);
    input_load = 1'b0;
  endtask

  task automatic start();
    sys_start = 1'b1;
    step(1);
    sys_start = 1'b0;
  endtask

  task automatic load_all(input logic [7:0] b);
    for (int p = 0; p < 32; p++) begin
      filter_addr = 5'(p);
      fbuf = {16{b}};
      filter_load = 1'b1;
      step(1);
    end
    filter_load = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 80) begin step(1); k++; end
    check({name, "_drain"}, 256'(sb.size()), 256'(0));
    step(2);
  endtask

  logic [191:0] exp_v;
  logic [127:0] ramp;
  logic [127:0] ones = {16{8'h01}};

  initial begin
    reset = 1'b0; enable = 1'b1; sys_start = 1'b0; filter_load = 1'b0; input_load = 1'b0;
    filter_addr = '0; sum_timestep = 8'd1; num_filter = 4'd8; num_kernel = 3'd4;
    ibuf = '0; fbuf = '0;

    // Reset: outputs clear, filter write during reset has no effect
    @(posedge clk); #1;
    filter_addr = 5'd0; fbuf = {16{8'h11}}; filter_load = 1'b1;
    step(2);
    check("reset_acc", 256'(acc), 256'(0));
    check("reset_obuf", 256'(obuf), 256'(0));
    filter_load = 1'b0;
    reset = 1'b1;
    step(1);

    // Not armed yet: load ignored
    run_pass(ones);
    step(25);
    check("unarmed_pulses", 256'(pulses), 256'(0));

    num_filter = 4'd1; num_kernel = 3'd1;
    start();
    expect_at(rows_all(24'h0), 18);
    run_pass(ones);
    wait_drain("zero_weights");

    // Uniform 0x11 weights, all ones input
    num_filter = 4'd8; num_kernel = 3'd4;
    load_all(8'h11);
    start();
    expect_at(rows_all(24'h000440), 18);
    run_pass(ones);
    wait_drain("w11_x01");

    // Weights -1, input 2, two columns
    load_all(8'hFF);
    num_kernel = 3'd2;
    expect_at(rows_all(24'hFFFFC0), 18);
    run_pass({16{8'h02}});
    wait_drain("wff_x02");

    // Three accumulated back-to-back passes, one pulse
    sum_timestep = 8'd3;
    expect_at(rows_all(24'hFFFF40), 52);
    run_pass({16{8'h02}});
    step(16);
    run_pass({16{8'h02}});
    step(16);
    run_pass({16{8'h02}});
    wait_drain("ts3");
    sum_timestep = 8'd1;

    // Ramp weights W[i]=i, input -1, three columns: 3 * -120
    for (int i = 0; i < 16; i++) ramp[i*8 +: 8] = 8'(i);
    for (int p = 0; p < 32; p++) begin
      filter_addr = 5'(p); fbuf = ramp; filter_load = 1'b1; step(1);
    end
    filter_load = 1'b0;
    num_kernel = 3'd3;
    expect_at(rows_all(24'hFFFE98), 18);
    run_pass({16{8'hFF}});
    wait_drain("ramp");

    // Per-PE weight = PE index: row m = 16*(16m+6)
    for (int p = 0; p < 32; p++) begin
      filter_addr = 5'(p); fbuf = {16{8'(p)}}; filter_load = 1'b1; step(1);
    end
    filter_load = 1'b0;
    num_kernel = 3'd4;
    for (int m = 0; m < 8; m++) exp_v[m*24 +: 24] = 24'(256*m + 96);
    expect_at(exp_v, 18);
    run_pass(ones);
    wait_drain("pe_index");

    // Three active rows, enable low 5 cycles mid-pass
    load_all(8'h11);
    num_filter = 4'd3;
    exp_v = '0;
    for (int m = 0; m < 3; m++) exp_v[m*24 +: 24] = 24'h000440;
    expect_at(exp_v, 23);
    run_pass(ones);
    step(4);
    enable = 1'b0;
    step(5);
    enable = 1'b1;
    wait_drain("nf3_stall");

    // Load while busy ignored
    num_filter = 4'd8;
    expect_at(rows_all(24'h000440), 18);
    run_pass(ones);
    step(4);
    run_pass({16{8'h05}});
    wait_drain("busy_load");

    // Async reset at c=7 aborts the pass
    run_pass(ones);
    step(7);
    reset = 1'b0;
    step(1);
    check("abort_acc", 256'(acc), 256'(0));
    check("abort_obuf", 256'(obuf), 256'(0));
    reset = 1'b1;
    step(30);
    check("abort_no_pulse", 256'(pulses), 256'(pushes));

    // sys_start wins over same-cycle input_load
    load_all(8'h11);
    start();
    ibuf = ones;
    sys_start = 1'b1; input_load = 1'b1;
    step(1);
    sys_start = 1'b0; input_load = 1'b0;
    step(25);
    check("start_load_no_pulse", 256'(pulses), 256'(pushes));
    expect_at(rows_all(24'h000440), 18);
    run_pass(ones);
    wait_drain("after_start");

    check("pulse_count", 256'(pulses), 256'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
